// File: rtl/reg_dump_reader.sv
// ---------------------------------------------------------------------------
// reg_dump_reader
//
// Sequential read-out engine for the register file. On a start request it
// walks an inclusive, wrap-around register-address range, drives the register
// file's combinational read port one address at a time and streams each
// captured word to a consumer over a valid/ready handshake.
//
// Optional feature (compile-time macro): REG_DUMP_CHECKSUM_EN
//   When defined, a running XOR of every transferred register word is sent as
//   one extra beat (out_addr=0, out_last=1) after the last register beat.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               dump request, sampled only while idle
//   start_addr/end_addr inclusive register range, sampled with start
//   rf_addr / rf_data   register file read port (data is combinational)
//   out_valid/out_ready beat handshake
//   out_data/out_addr   captured word and its register index
//   out_last            final beat of the dump
//   busy                high while a dump is in progress (including done)
//   done                one-cycle pulse after the final beat transfers
// ---------------------------------------------------------------------------
module reg_dump_reader #(
    parameter int unsigned NUM_REG        = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned REG_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [REG_ADDR_WIDTH-1:0] start_addr,
    input  logic [REG_ADDR_WIDTH-1:0] end_addr,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr,
    input  logic [REG_WIDTH-1:0]      rf_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REG_WIDTH-1:0]      out_data,
    output logic [REG_ADDR_WIDTH-1:0] out_addr,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    // StSum is the extra fetch-equivalent cycle for the checksum beat; it is
    // unreachable when the checksum feature is compiled out.
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSend,
        StDone,
        StSum
    } state_e;

    state_e                    state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [REG_ADDR_WIDTH-1:0] last_q, last_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic [REG_WIDTH-1:0]      out_data_q, out_data_d;
    logic [REG_ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [REG_WIDTH-1:0]      csum_q, csum_d;
`endif

    logic [REG_ADDR_WIDTH-1:0] cur_inc;
    logic                      at_last;

    // Next address with wrap at NUM_REG.
    assign cur_inc = REG_ADDR_WIDTH'((32'(cur_q) + 32'd1) % NUM_REG);
    assign at_last = (cur_q == last_q);

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cur_d   = start_addr;
                    last_d  = end_addr;
                    state_d = StFetch;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end

            StFetch: begin
                // Snapshot the word now; later register writes cannot reach out_data.
                out_data_d  = rf_data;
                out_addr_d  = cur_q;
                out_valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                out_last_d  = 1'b0;
`else
                out_last_d  = at_last;
`endif
                state_d     = StSend;
            end

            StSend: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
                    if (!out_last_q) begin
                        csum_d = csum_q ^ out_data_q;
                    end
                    if (out_last_q) begin
                        state_d = StDone;
                    end else if (at_last) begin
                        state_d = StSum;
                    end else begin
                        cur_d   = cur_inc;
                        state_d = StFetch;
                    end
`else
                    if (out_last_q) begin
                        state_d = StDone;
                    end else begin
                        cur_d   = cur_inc;
                        state_d = StFetch;
                    end
`endif
                end
            end

`ifdef REG_DUMP_CHECKSUM_EN
            StSum: begin
                // csum_q already includes the final register word here.
                out_data_d  = csum_q;
                out_addr_d  = '0;
                out_valid_d = 1'b1;
                out_last_d  = 1'b1;
                state_d     = StSend;
            end
`endif

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            last_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign rf_addr   = cur_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_reg_dump_reader.sv
// ---------------------------------------------------------------------------
// Testbench for reg_dump_reader. The expected beat list for each dump is
// built from the register-file contents and the range rules (plus the XOR
// checksum beat when REG_DUMP_CHECKSUM_EN is defined).
// ---------------------------------------------------------------------------
module tb_reg_dump_reader;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf [NR];
    beat_t         exp_q [$];
    int            errors = 0;
    int            checks = 0;

    assign rf_data = rf[rf_addr];

    always #5 clk = ~clk;

    reg_dump_reader #(
        .NUM_REG        (NR),
        .REG_ADDR_WIDTH (AW),
        .REG_WIDTH      (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    task automatic rf_identity();
        for (int i = 0; i < NR; i++) rf[i] = DW'(i);
    endtask

    // Expected beats: range s..e inclusive with wrap, data from current rf.
    task automatic build_exp(input logic [AW-1:0] s, input logic [AW-1:0] e);
        int            n;
        logic [DW-1:0] x;
        beat_t         b;
        exp_q.delete();
        n = ((int'(e) - int'(s) + NR) % NR) + 1;
        x = '0;
        for (int i = 0; i < n; i++) begin
            b.a = AW'((int'(s) + i) % NR);
            b.d = rf[b.a];
            b.l = (i == n - 1) && !CSUM;
            x   = x ^ b.d;
            exp_q.push_back(b);
        end
        if (CSUM) begin
            b.a = '0;
            b.d = x;
            b.l = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    // mode 0: ready always high; 1: ready low 3 cycles per beat; 2: random.
    // timed: check beat cadence and done cycle (mode 0 only).
    task automatic run_dump(input logic [AW-1:0] s, input logic [AW-1:0] e, input int mode,
                            input bit poke, input bit wr2, input bit timed);
        int    cyc;
        int    wait_cnt;
        int    n_exp;
        bit    finished;
        logic  r;
        build_exp(s, e);
        n_exp = exp_q.size();
        @(negedge clk);
        start = 1'b1; start_addr = s; end_addr = e;
        out_ready = (mode == 0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; start_addr = ~s; end_addr = ~e;
        cyc = 1; wait_cnt = 0; finished = 1'b0;
        while (!finished && cyc < 400) begin
            if (poke && cyc == 3) begin
                start = 1'b1; start_addr = s + AW'(3); end_addr = s + AW'(3);
            end else begin
                start = 1'b0;
            end
            if (done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL done_early: beats left %0d, required 0", exp_q.size());
                end
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_at_done: got %b, required 1", busy);
                end
                if (timed) begin
                    checks++;
                    if (cyc != 2 * n_exp + 1) begin
                        errors++;
                        $display("FAIL done_cycle: got %0d, required %0d", cyc, 2 * n_exp + 1);
                    end
                end
                finished = 1'b1;
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_in_dump: cycle %0d got %b, required 1", cyc, busy);
                end
                if (timed) begin
                    checks++;
                    if (out_valid !== (cyc % 2 == 0)) begin
                        errors++;
                        $display("FAIL valid_cadence: cycle %0d got %b, required %b",
                                 cyc, out_valid, (cyc % 2 == 0));
                    end
                end
                if (out_valid === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat: addr %0d data %h, required none",
                                 out_addr, out_data);
                    end else if (out_addr !== exp_q[0].a || out_data !== exp_q[0].d ||
                                 out_last !== exp_q[0].l) begin
                        errors++;
                        $display("FAIL beat: got (%0d,%h,%b), required (%0d,%h,%b)",
                                 out_addr, out_data, out_last,
                                 exp_q[0].a, exp_q[0].d, exp_q[0].l);
                    end
                    if (wr2 && out_addr == AW'(2)) rf[2] = 32'hA5;
                    case (mode)
                        0:       r = 1'b1;
                        1:       r = (wait_cnt >= 3);
                        default: r = 1'(($urandom_range(0, 1)));
                    endcase
                    out_ready = r;
                    if (r) begin
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    // ready without valid must be ignored
                    out_ready = (mode == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL dump_timeout: no done within %0d cycles", cyc);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL after_done: busy %b done %b, required 0 0", busy, done);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || out_addr !== '0 ||
            rf_addr !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: v%b l%b d%h a%0d rfa%0d b%b dn%b, required all 0",
                     out_valid, out_last, out_data, out_addr, rf_addr, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy %b valid %b done %b, required 0 0 0",
                     busy, out_valid, done);
        end
    endtask

    task automatic test_basic();
        rf_identity();
        run_dump(5'd0, 5'd5, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        rf_identity();
        run_dump(5'd0, 5'd5, 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        rf_identity();
        run_dump(5'd30, 5'd1, 0, 1'b0, 1'b0, 1'b1);
        run_dump(5'd3, 5'd3, 0, 1'b0, 1'b0, 1'b1);
        run_dump(5'd8, 5'd7, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_ignore_start();
        rf_identity();
        run_dump(5'd0, 5'd5, 0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        bit seen;
        rf_identity();
        @(negedge clk);
        start = 1'b1; start_addr = 5'd0; end_addr = 5'd9; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_dump_valid: got no beat, required a beat within 10 cycles");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rf_addr !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid %b busy %b done %b rf_addr %0d, required 0 0 0 0",
                     out_valid, busy, done, rf_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL no_done_after_reset: done %b busy %b, required 0 0", done, busy);
            end
        end
        run_dump(5'd4, 5'd6, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_snapshot();
        rf_identity();
        run_dump(5'd0, 5'd3, 1, 1'b0, 1'b1, 1'b0);
        run_dump(5'd2, 5'd2, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_checksum();
        rf_identity();
        run_dump(5'd1, 5'd5, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [AW-1:0] s;
        logic [AW-1:0] e;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NR; i++) rf[i] = $urandom;
            s = AW'($urandom_range(0, NR - 1));
            e = AW'($urandom_range(0, NR - 1));
            run_dump(s, e, 2, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < NR; i++) rf[i] = $urandom;
        s = AW'($urandom_range(0, NR - 1));
        run_dump(s, s - AW'(1), 0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rf_identity();
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_ignore_start();
        test_reset_mid();
        test_snapshot();
        test_checksum();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
